pwm_deadtime: RTL and testbench
===============================

# pwm_deadtime

Complementary-output dead-time generator that sits directly downstream of the PWM generator. It consumes the single-ended PWM waveform and drives a high-side and low-side gate signal pair. The pair is never active at the same time, and a programmable all-off gap separates every hand-over. The block also counts input pulses that are too short to survive dead-time insertion, for diagnostic read-back over the same register interface as the generator.

## Interface
- WIDTH, 32: width of `dead_rise`, `dead_fall` and `control`; the dead-time counter is WIDTH bits.
- CNT_WIDTH, 16: width of the swallowed-pulse counter.
- clk  input  1  system clock; all state changes on posedge.
- rst  input  1  reset, asynchronous, active-low.
- pwm_in  input  1  PWM waveform from the generator; registered upstream and stable at posedge.
- dead_rise  input  WIDTH  dead value D_r applied before `out_hi` turns on.
- dead_fall  input  WIDTH  dead value D_f applied before `out_lo` turns on.
- control  input  WIDTH  bit 0 = enable; other bits ignored.
- out_hi  output  1  high-side drive, active-high, registered.
- out_lo  output  1  low-side drive, active-high, registered.
- in_dead  output  1  high while in a dead-time state, registered.
- swallow_cnt  output  CNT_WIDTH  count of input edges cancelled during dead time; saturating.
- fault_n  input  1  present only with `PWM_DT_FAULT_EN`; active-low external trip.
- fault  output  1  present only with `PWM_DT_FAULT_EN`; sticky trip flag.

## Operation
- States: OFF, DT_LO, LO, DT_HI, HI (FAULT with macro).
- Outputs are Moore outputs, registered with the state:
  - `out_lo` = 1 in LO only.
  - `out_hi` = 1 in HI only.
  - `in_dead` = 1 in DT_LO or DT_HI.
- Dead counter `cnt` is loaded with D on entry to a DT state.
  - In a DT state: if `cnt` == 0, advance; else decrement.
  - A DT state therefore lasts D+1 cycles, so the minimum gap is 1 cycle even with D = 0.
- Transitions:
  - OFF: if enable, go to DT_LO and load D_f.
  - DT_LO: if `pwm_in` = 1, go to HI (the low side was never on); else if `cnt` == 0, go to LO.
  - LO: if `pwm_in` = 1, go to DT_HI and load D_r.
  - DT_HI: if `pwm_in` = 0, go to LO and increment `swallow_cnt`; else if `cnt` == 0, go to HI.
  - HI: if `pwm_in` = 0, go to DT_LO, load D_f, and increment `swallow_cnt` only on a DT_LO abort.
  - Exact rule: `swallow_cnt` increments on any DT_HI→LO or DT_LO→HI transition.
  - Exception: the DT_LO→HI transition taken directly after OFF does not count.
- Enable low in any state: next state is OFF, outputs 00, `cnt` = 0, `swallow_cnt` cleared.
- `swallow_cnt` saturates at all-ones.
- `dead_rise` and `dead_fall` are sampled only at DT entry. Changes mid-dead-time do not affect the running gap.
- Invariant: `out_hi` & `out_lo` is never 1, in any cycle, including reset and enable toggling.

## Timing
- Reset (async assert, synchronous release on posedge): state OFF; `out_hi`, `out_lo`, `in_dead` = 0; `cnt` = 0; `swallow_cnt` = 0; `fault` = 0.
- `pwm_in` rise sampled at edge k from LO:
  - `out_lo` falls after edge k.
  - `out_hi` rises after edge k+D_r+1.
- `pwm_in` fall mirrors the rise with D_f.
- Enable deassert sampled at edge k: both outputs are 0 after edge k.
- Enable assert at edge k with `pwm_in` = 0: `out_lo` rises after edge k+D_f+2 (one cycle in OFF→DT_LO, then D_f+1 in DT_LO).
- D = all-ones: the counter does not wrap; the gap is 2^WIDTH cycles.

## Configuration
- `PWM_DT_FAULT_EN` defined:
  - Adds `fault_n` and `fault`.
  - `fault_n` passes through a 2-flop synchronizer.
  - Synchronized low forces FAULT from any state: outputs 00, `fault` = 1.
  - Trip latency from `fault_n` falling to outputs off is at most 3 posedges.
  - FAULT is left only via enable low (to OFF), which also clears `fault`, and only if synchronized `fault_n` = 1.
  - Reset clears FAULT.
- `PWM_DT_FAULT_EN` undefined: neither port exists and there is no FAULT state.

## Test plan
- Reset mid-HI with D_r = D_f = 3: outputs 00 immediately, asynchronously; after release and enable, `out_lo` rises 5 cycles after enable sample.
- Enable, `pwm_in` 50% square wave with period 40 and D_r = 2, D_f = 5: `out_lo`→`out_hi` gap = 3 cycles, `out_hi`→`out_lo` gap = 6 cycles, `swallow_cnt` = 0.
- D_r = 0: gap exactly 1 cycle; assert `out_hi` & `out_lo` never 1 over 10,000 random `pwm_in` cycles.
- D_r = 8, `pwm_in` high pulse of 4 cycles from LO: `out_hi` never rises, `out_lo` back after 4 cycles, `swallow_cnt` = 1; repeat 70,000 times with CNT_WIDTH = 16: saturates at 65535.
- Deassert enable while in DT_HI with `cnt` = 5: OFF next cycle, outputs 00, `swallow_cnt` = 0.
- With `PWM_DT_FAULT_EN`, in HI: drive `fault_n` low, outputs 00 and `fault` = 1 within 3 cycles; toggling `pwm_in` has no effect; enable low with `fault_n` high clears `fault`.

Source files
------------

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: turns one PWM waveform into a non-overlapping high/low gate pair with programmable dead time.
// Latency: outputs registered with the state; an input edge starts the hand-over on the next clock, and each gap lasts D+1 cycles.
// Backpressure: none; free-running waveform in and out. Optional trip input and flag are enabled by the PWM_DT_FAULT_EN macro.
module pwm_deadtime #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pwm_in,
  input  logic [WIDTH-1:0]     dead_rise,
  input  logic [WIDTH-1:0]     dead_fall,
  input  logic [WIDTH-1:0]     control,
  output logic                 out_hi,
  output logic                 out_lo,
  output logic                 in_dead,
`ifdef PWM_DT_FAULT_EN
  input  logic                 fault_n,
  output logic                 fault,
`endif
  output logic [CNT_WIDTH-1:0] swallow_cnt
);

`ifdef PWM_DT_FAULT_EN
  typedef enum logic [2:0] {
    ST_OFF, ST_DT_LO, ST_LO, ST_DT_HI, ST_HI, ST_FAULT
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_OFF, ST_DT_LO, ST_LO, ST_DT_HI, ST_HI
  } state_t;
`endif

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic             from_off, from_off_nxt;
  logic             en_q;
  logic             swallow_inc, swallow_clr;
  logic             enable;
  logic             unused_ctrl;

  assign enable      = control[0];
  assign unused_ctrl = ^control[WIDTH-1:1];

`ifdef PWM_DT_FAULT_EN
  logic fault_sync1, fault_sync2;

  // Two-flop synchronizer for the asynchronous trip input; idles high (not tripped).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault_sync1 <= 1'b1;
      fault_sync2 <= 1'b1;
    end else begin
      fault_sync1 <= fault_n;
      fault_sync2 <= fault_sync1;
    end
  end
`endif

  // Next-state logic. OFF dwells one extra cycle after enable is first seen (en_q),
  // so the low side comes up D_f+2 cycles after the enable sample.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    from_off_nxt = from_off;
    swallow_inc  = 1'b0;
    swallow_clr  = 1'b0;
    if (!enable) begin
      state_nxt    = ST_OFF;
      cnt_nxt      = '0;
      from_off_nxt = 1'b0;
      swallow_clr  = 1'b1;
    end else begin
      case (state)
        ST_OFF: begin
          if (en_q) begin
            state_nxt    = ST_DT_LO;
            cnt_nxt      = dead_fall;
            from_off_nxt = 1'b1;
          end
        end
        ST_DT_LO: begin
          // pwm rose again before the low side came on: skip straight back to high.
          if (pwm_in) begin
            state_nxt   = ST_HI;
            swallow_inc = !from_off;
          end else if (cnt == '0) begin
            state_nxt = ST_LO;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        ST_LO: begin
          if (pwm_in) begin
            state_nxt = ST_DT_HI;
            cnt_nxt   = dead_rise;
          end
        end
        ST_DT_HI: begin
          // pwm fell before the high side came on: the pulse is swallowed.
          if (!pwm_in) begin
            state_nxt   = ST_LO;
            swallow_inc = 1'b1;
          end else if (cnt == '0) begin
            state_nxt = ST_HI;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        ST_HI: begin
          if (!pwm_in) begin
            state_nxt    = ST_DT_LO;
            cnt_nxt      = dead_fall;
            from_off_nxt = 1'b0;
          end
        end
        default: begin
          // FAULT (when built) holds while enable stays high.
          state_nxt = state;
        end
      endcase
    end
`ifdef PWM_DT_FAULT_EN
    // A synchronized trip overrides everything, including enable handling.
    if (!fault_sync2) begin
      state_nxt    = ST_FAULT;
      cnt_nxt      = '0;
      from_off_nxt = 1'b0;
      swallow_inc  = 1'b0;
    end
`endif
  end

  // State, dead counter and Moore outputs registered together from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_OFF;
      cnt      <= '0;
      from_off <= 1'b0;
      en_q     <= 1'b0;
      out_hi   <= 1'b0;
      out_lo   <= 1'b0;
      in_dead  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      from_off <= from_off_nxt;
      en_q     <= enable;
      out_hi   <= (state_nxt == ST_HI);
      out_lo   <= (state_nxt == ST_LO);
      in_dead  <= (state_nxt == ST_DT_LO) || (state_nxt == ST_DT_HI);
    end
  end

`ifdef PWM_DT_FAULT_EN
  // Sticky trip flag, cleared only by leaving FAULT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fault <= 1'b0;
    end else begin
      fault <= (state_nxt == ST_FAULT);
    end
  end
`endif

  // Saturating swallowed-pulse counter, cleared while disabled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      swallow_cnt <= '0;
    end else if (swallow_clr) begin
      swallow_cnt <= '0;
    end else if (swallow_inc && (swallow_cnt != {CNT_WIDTH{1'b1}})) begin
      swallow_cnt <= swallow_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// tb_pwm_deadtime: randomized stimulus against a gap/side reference model with a queued scoreboard.
// Latency: one expected entry per clock, popped just after the edge it describes.
// Backpressure: none; the monitor pops whenever an entry is due.
module tb_pwm_deadtime;
  localparam int W  = 32;
  localparam int CW = 4;
  localparam int SIDE_NONE = 0;
  localparam int SIDE_LO   = 1;
  localparam int SIDE_HI   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          pwm_in = 1'b0;
  logic [W-1:0]  dead_rise = '0;
  logic [W-1:0]  dead_fall = '0;
  logic [W-1:0]  control = '0;
  logic          out_hi, out_lo, in_dead;
  logic [CW-1:0] swallow_cnt;
  logic          flt_w;
`ifdef PWM_DT_FAULT_EN
  logic          fault_n = 1'b1;
  logic          fault;
  assign flt_w = fault;
`else
  assign flt_w = 1'b0;
`endif

  pwm_deadtime #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .dead_rise   (dead_rise),
    .dead_fall   (dead_fall),
    .control     (control),
    .out_hi      (out_hi),
    .out_lo      (out_lo),
    .in_dead     (in_dead),
`ifdef PWM_DT_FAULT_EN
    .fault_n     (fault_n),
    .fault       (fault),
`endif
    .swallow_cnt (swallow_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          hi;
    logic          lo;
    logic          dead;
    logic          flt;
    logic [CW-1:0] sw;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  logic async_tgl = 1'b0;

  // Stimulus values applied at the next falling edge.
  bit cur_rst, cur_fn;
  int cur_dr, cur_df;

  // Reference model: which side is driven, and how many gap cycles remain toward which side.
  int m_drive, m_gap, m_toward, m_sw;
  bit m_fresh, m_en_prev, m_trip, m_s1, m_s2;

  task automatic model_reset();
    m_drive = SIDE_NONE; m_gap = 0; m_toward = SIDE_NONE; m_sw = 0;
    m_fresh = 0; m_en_prev = 0; m_trip = 0; m_s1 = 1; m_s2 = 1;
  endtask

  task automatic bump();
    if (m_sw < (1 << CW) - 1) m_sw++;
  endtask

  task automatic model_edge(input bit en, input bit pwm, input int dr, input int df, input bit fn);
    bit s;
    s = m_s2; m_s2 = m_s1; m_s1 = fn;
    if (!en) m_sw = 0;
    if (!s) begin
      m_trip = 1; m_drive = SIDE_NONE; m_gap = 0;
    end else if (m_trip) begin
      if (!en) m_trip = 0;
    end else if (!en) begin
      m_drive = SIDE_NONE; m_gap = 0;
    end else if (m_gap > 0) begin
      if (m_toward == SIDE_LO && pwm) begin
        m_gap = 0; m_drive = SIDE_HI;
        if (!m_fresh) bump();
      end else if (m_toward == SIDE_HI && !pwm) begin
        m_gap = 0; m_drive = SIDE_LO;
        bump();
      end else begin
        m_gap--;
        if (m_gap == 0) m_drive = m_toward;
      end
    end else if (m_drive == SIDE_LO) begin
      if (pwm) begin m_gap = dr + 1; m_toward = SIDE_HI; m_drive = SIDE_NONE; end
    end else if (m_drive == SIDE_HI) begin
      if (!pwm) begin m_gap = df + 1; m_toward = SIDE_LO; m_drive = SIDE_NONE; m_fresh = 0; end
    end else if (m_en_prev) begin
      m_gap = df + 1; m_toward = SIDE_LO; m_fresh = 1;
    end
    m_en_prev = en;
  endtask

  task automatic push_expected();
    exp_t e;
    e.hi   = (m_drive == SIDE_HI);
    e.lo   = (m_drive == SIDE_LO);
    e.dead = (m_gap > 0);
    e.flt  = m_trip;
    e.sw   = CW'(m_sw);
    exp_q.push_back(e);
  endtask

  // One clock of stimulus: drive on the falling edge, predict the next rising edge.
  task automatic cycle(input bit en, input bit pwm);
    @(negedge clk);
    rst       = cur_rst;
    control   = {{(W-1){1'b0}}, en};
    pwm_in    = pwm;
    dead_rise = W'(cur_dr);
    dead_fall = W'(cur_df);
`ifdef PWM_DT_FAULT_EN
    fault_n   = cur_fn;
`endif
    if (!cur_rst) model_reset();
    else model_edge(en, pwm, cur_dr, cur_df, cur_fn);
    push_expected();
  endtask

  // Assert reset between clock edges; outputs must drop without a clock.
  task automatic async_reset();
    @(posedge clk);
    #2;
    cur_rst = 0;
    rst = 1'b0;
    model_reset();
    push_expected();
    async_tgl = ~async_tgl;
  endtask

  // Monitor: pops one expectation after every rising edge or asynchronous reset.
  initial begin
    exp_t e, got;
    forever begin
      @(posedge clk or async_tgl);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got.hi = out_hi; got.lo = out_lo; got.dead = in_dead; got.flt = flt_w; got.sw = swallow_cnt;
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got hi=%0b lo=%0b dead=%0b flt=%0b sw=%0d want hi=%0b lo=%0b dead=%0b flt=%0b sw=%0d",
                   $time, got.hi, got.lo, got.dead, got.flt, got.sw, e.hi, e.lo, e.dead, e.flt, e.sw);
        end
        vectors++;
        if ((out_hi & out_lo) !== 1'b0) begin
          miscompares++;
          $display("FAIL overlap t=%0t got hi&lo=%0b want 0", $time, out_hi & out_lo);
        end
      end
    end
  end

  initial begin
    int run;
    bit lvl;
    cur_rst = 0; cur_fn = 1; cur_dr = 0; cur_df = 0;
    model_reset();
    repeat (3) cycle(0, 0);
    cur_rst = 1;

    // D=3: come up low, go high, then reset in the middle of HI.
    cur_dr = 3; cur_df = 3;
    repeat (8) cycle(1, 0);
    repeat (8) cycle(1, 1);
    async_reset();
    repeat (2) cycle(0, 0);
    cur_rst = 1;
    repeat (8) cycle(1, 0);

    // 50% square wave, period 40, asymmetric dead times.
    cur_dr = 2; cur_df = 5;
    for (int i = 0; i < 200; i++) cycle(1, (i % 40) >= 20);

    // Zero rise dead time with random pwm; fall dead time changes on the fly.
    cur_dr = 0;
    for (int i = 0; i < 3000; i++) begin
      cur_df = $urandom_range(0, 3);
      cycle(1, 1'($urandom_range(0, 1)));
    end

    // 4-cycle pulses against an 8-cycle rise gap: every pulse is swallowed, counter saturates.
    cur_dr = 8; cur_df = 1;
    repeat (12) cycle(1, 0);
    for (int i = 0; i < 20; i++) begin
      repeat (4) cycle(1, 1);
      repeat (6) cycle(1, 0);
    end

    // Drop enable while the rise gap still has 5 counts left.
    repeat (4) cycle(1, 1);
    cycle(0, 1);
    repeat (2) cycle(0, 0);

    // Fully random: run lengths, dead times, occasional enable drops.
    lvl = 0; run = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run == 0) begin
        lvl = ~lvl;
        run = $urandom_range(1, 12);
      end
      run--;
      if ($urandom_range(0, 15) == 0) cur_dr = $urandom_range(0, 6);
      if ($urandom_range(0, 15) == 0) cur_df = $urandom_range(0, 6);
      cycle($urandom_range(0, 199) != 0, lvl);
    end

`ifdef PWM_DT_FAULT_EN
    // Trip while driving high; pwm is ignored until enable drops with the trip released.
    cur_dr = 1; cur_df = 1;
    repeat (2) cycle(0, 0);
    repeat (10) cycle(1, 0);
    repeat (6) cycle(1, 1);
    cur_fn = 0;
    repeat (6) cycle(1, 1'($urandom_range(0, 1)));
    cur_fn = 1;
    repeat (4) cycle(1, 1);
    repeat (3) cycle(0, 0);
    repeat (10) cycle(1, 0);
`endif

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
